// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store memory master.
//   lsu_size_t  - access size encoding on core_size (3 is illegal)
//   lsu_state_t - transaction FSM states
//   is_misaligned() - natural-alignment check for a size/offset pair
package lsu_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} lsu_state_t;

  // Size 3 has no legal meaning, so it is reported as misaligned and never
  // reaches the memory.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic mis;
    case (lsu_size_t'(size))
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = offset[0];
      SZ_W:    mis = (offset != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational byte-lane steering.
//   size, load_unsigned, offset, wen - attributes of the latched request
//   store_data   - right-justified store data from the core
//   store_wdata  - store data moved onto its byte lane(s)
//   store_wbmask - byte write mask on the lane(s); zero for loads
//   load_word    - word returned by the memory
//   load_data    - selected lane, zero- or sign-extended to 32 bits
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [1:0]  offset,
  input  logic        wen,
  input  logic [31:0] store_data,
  output logic [31:0] store_wdata,
  output logic [3:0]  store_wbmask,
  input  logic [31:0] load_word,
  output logic [31:0] load_data
);

  logic [3:0]  base_mask;
  logic [31:0] lane;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    base_mask = 4'b1111;
    case (lsu_size_t'(size))
      SZ_B:    base_mask = 4'b0001;
      SZ_H:    base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
  end

  assign store_wdata  = store_data << {offset, 3'b000};
  assign store_wbmask = wen ? (base_mask << offset) : 4'b0000;

  assign lane = load_word >> {offset, 3'b000};

  always_comb begin
    load_data = lane;
    case (lsu_size_t'(size))
      SZ_B: load_data = load_unsigned ? {24'h0, lane[7:0]}
                                      : {{24{lane[7]}}, lane[7:0]};
      SZ_H: load_data = load_unsigned ? {16'h0, lane[15:0]}
                                      : {{16{lane[15]}}, lane[15:0]};
      default: load_data = lane;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: initiator side of the ram reqValid/respValid handshake.
// Accepts one load/store from the core, issues one word-aligned request,
// waits for the response (or a timeout) and returns extended load data.
//   clock, reset        - rising-edge clock, async active-low reset
//   core_*              - request from / completion to the execute stage
//   mem_reqValid, mem_* - single-cycle request to the ram, held during WAIT
//   mem_respValid/rdata - one-cycle completion from the ram
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            core_valid,
  output logic            core_ready,
  input  logic            core_wen,
  input  logic [1:0]      core_size,
  input  logic            core_unsigned,
  input  logic [XLEN-1:0] core_addr,
  input  logic [XLEN-1:0] core_wdata,
  output logic            core_done,
  output logic [XLEN-1:0] core_rdata,
  output logic            core_misalign,
  output logic            core_timeout,
  output logic            mem_reqValid,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wbmask,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_respValid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  lsu_state_t      state;
  logic            wen_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            misalign_q;
  logic            timeout_q;
  logic [TW-1:0]   timer;

  logic [XLEN-1:0] load_data;

  lsu_align u_align (
    .size          (size_q),
    .load_unsigned (uns_q),
    .offset        (addr_q[1:0]),
    .wen           (wen_q),
    .store_data    (wdata_q),
    .store_wdata   (mem_wdata),
    .store_wbmask  (mem_wbmask),
    .load_word     (mem_rdata),
    .load_data     (load_data)
  );

  // NOTE: state uses non-blocking assignments and the asynchronous reset
  // clears every register, so all request outputs drop to 0 the moment
  // reset asserts, even mid-transaction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      wen_q      <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
      timer      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (core_valid) begin
            wen_q      <= core_wen;
            size_q     <= core_size;
            uns_q      <= core_unsigned;
            addr_q     <= core_addr;
            wdata_q    <= core_wdata;
            rdata_q    <= '0;
            timeout_q  <= 1'b0;
            if (is_misaligned(core_size, core_addr[1:0])) begin
              misalign_q <= 1'b1;
              state      <= S_DONE;
            end else begin
              misalign_q <= 1'b0;
              state      <= S_REQ;
            end
          end
        end
        S_REQ: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A response on the expiry cycle still counts as a success.
          if (mem_respValid) begin
            rdata_q <= wen_q ? '0 : load_data;
            state   <= S_DONE;
          end else if (timer == TIMER_MAX) begin
            timeout_q <= 1'b1;
            state     <= S_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DONE: begin
          rdata_q    <= '0;
          misalign_q <= 1'b0;
          timeout_q  <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign core_ready    = (state == S_IDLE);
  assign core_done     = (state == S_DONE);
  assign core_rdata    = core_done ? rdata_q : '0;
  assign core_misalign = core_done & misalign_q;
  assign core_timeout  = core_done & timeout_q;

  // The request fields come straight from the latched registers, so they
  // stay stable for the whole WAIT period without extra holding logic.
  assign mem_reqValid = (state == S_REQ);
  assign mem_wen      = wen_q;
  assign mem_addr     = {addr_q[XLEN-1:2], 2'b00};

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: lsu_mem_master paired with a behavioural ram responder.
// Expected completions and requests are queued when an operation is driven
// and compared by a monitor on the falling edge when the DUT produces them.
module tb_lsu_mem_master;

  localparam int TIMEOUT_CYCLES = 64;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        to;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } req_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        core_valid = 1'b0;
  logic        core_ready;
  logic        core_wen = 1'b0;
  logic [1:0]  core_size = 2'd0;
  logic        core_unsigned = 1'b0;
  logic [31:0] core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic        core_done;
  logic [31:0] core_rdata;
  logic        core_misalign;
  logic        core_timeout;
  logic        mem_reqValid;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wbmask;
  logic [31:0] mem_addr;
  logic        mem_respValid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int req_pulses = 0;
  int ready_viol = 0;

  rsp_t rsp_q[$];
  req_t req_q[$];

  // ram model controls
  logic [31:0] ram [0:255];
  int          resp_delay   = 5;
  bit          responder_on = 1'b1;
  bit          late_pulse   = 1'b0;

  always #5 clock = ~clock;

  lsu_mem_master #(.XLEN(32), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clock         (clock),
    .reset         (reset),
    .core_valid    (core_valid),
    .core_ready    (core_ready),
    .core_wen      (core_wen),
    .core_size     (core_size),
    .core_unsigned (core_unsigned),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_done     (core_done),
    .core_rdata    (core_rdata),
    .core_misalign (core_misalign),
    .core_timeout  (core_timeout),
    .mem_reqValid  (mem_reqValid),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wbmask    (mem_wbmask),
    .mem_addr      (mem_addr),
    .mem_respValid (mem_respValid),
    .mem_rdata     (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // ram responder: request seen in cycle N answers in cycle N+resp_delay.
  initial begin
    int          cnt;
    logic [7:0]  idx;
    cnt = 0;
    idx = '0;
    for (int i = 0; i < 256; i++) ram[i] = '0;
    forever begin
      @(posedge clock);
      #1;
      mem_respValid = 1'b0;
      if (!reset) begin
        cnt = 0;
      end else begin
        if (late_pulse) begin
          mem_respValid = 1'b1;
          mem_rdata     = 32'hBAD0BAD0;
          late_pulse    = 1'b0;
        end
        if (cnt != 0) begin
          cnt--;
          if (cnt == 0) begin
            mem_respValid = 1'b1;
            mem_rdata     = ram[idx];
          end
        end
        if (mem_reqValid && responder_on) begin
          idx = mem_addr[9:2];
          if (mem_wen)
            for (int b = 0; b < 4; b++)
              if (mem_wbmask[b]) ram[idx][8*b +: 8] = mem_wdata[8*b +: 8];
          cnt = resp_delay;
        end
      end
    end
  end

  // Monitor: pop and compare whenever the DUT completes or issues a request.
  initial begin
    rsp_t r;
    req_t q;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (core_done) begin
          n_done++;
          if (rsp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
          else begin
            r = rsp_q.pop_front();
            check("rsp_rdata",    core_rdata, r.rdata);
            check("rsp_misalign", {31'd0, core_misalign}, {31'd0, r.mis});
            check("rsp_timeout",  {31'd0, core_timeout},  {31'd0, r.to});
          end
        end
        if (mem_reqValid) begin
          req_pulses++;
          if (req_q.size() == 0) check("unexpected_req", 32'd1, 32'd0);
          else begin
            q = req_q.pop_front();
            check("req_addr",   mem_addr, q.addr);
            check("req_wen",    {31'd0, mem_wen}, {31'd0, q.wen});
            check("req_wbmask", {28'd0, mem_wbmask}, {28'd0, q.mask});
            check("req_wdata",  mem_wdata, q.wdata);
          end
        end
        if (core_ready && (core_done || mem_reqValid)) ready_viol++;
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!core_ready && n < 200) begin
      @(posedge clock); #1; n++;
    end
    if (!core_ready) check("ready_wait", 32'd0, 32'd1);
  endtask

  // Drive one operation at posedge+1 and time its completion in cycles.
  task automatic do_op(input string tag, input logic wen, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_mis, input logic exp_to,
                       input logic [3:0] exp_mask, input logic [31:0] exp_wdata,
                       input int exp_lat);
    rsp_t r;
    req_t q;
    int   lat;
    wait_ready();
    r.rdata = exp_rdata; r.mis = exp_mis; r.to = exp_to;
    rsp_q.push_back(r);
    if (!exp_mis) begin
      q.addr = {addr[31:2], 2'b00}; q.wen = wen; q.mask = exp_mask; q.wdata = exp_wdata;
      req_q.push_back(q);
    end
    core_valid = 1'b1; core_wen = wen; core_size = size; core_unsigned = uns;
    core_addr = addr; core_wdata = wdata;
    @(posedge clock); #1;
    core_valid = 1'b0;
    lat = 1;
    while (!core_done && lat < 200) begin
      @(posedge clock); #1; lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    @(posedge clock); #1;
  endtask

  initial begin
    int base_pulses;
    int base_done;
    int acc;
    int cyc;
    req_t q;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready",  {31'd0, core_ready}, 32'd1);
    check("rst_done",   {31'd0, core_done},  32'd0);
    check("rst_reqv",   {31'd0, mem_reqValid}, 32'd0);
    check("rst_addr",   mem_addr, 32'd0);
    check("rst_wbmask", {28'd0, mem_wbmask}, 32'd0);
    check("rst_rdata",  core_rdata, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;

    do_op("sw100",  1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 4'hF,    32'hDEADBEEF, 7);
    do_op("lw100",  0, 2'd2, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 4'h0,    32'h0,        7);
    do_op("sb103",  1, 2'd0, 0, 32'h103, 32'h80,       32'h0,        0, 0, 4'b1000, 32'h80000000, 7);
    do_op("lb103",  0, 2'd0, 0, 32'h103, 32'h0,        32'hFFFFFF80, 0, 0, 4'h0,    32'h0,        7);
    do_op("lbu103", 0, 2'd0, 1, 32'h103, 32'h0,        32'h00000080, 0, 0, 4'h0,    32'h0,        7);
    do_op("sw_b",   1, 2'd2, 0, 32'h100, 32'h12348765, 32'h0,        0, 0, 4'hF,    32'h12348765, 7);
    do_op("lh102",  0, 2'd1, 0, 32'h102, 32'h0,        32'h00001234, 0, 0, 4'h0,    32'h0,        7);
    do_op("lh100",  0, 2'd1, 0, 32'h100, 32'h0,        32'hFFFF8765, 0, 0, 4'h0,    32'h0,        7);

    // Misaligned accesses: immediate done, no memory request
    base_pulses = req_pulses;
    do_op("lh101",  0, 2'd1, 0, 32'h101, 32'h0, 32'h0, 1, 0, 4'h0, 32'h0, 1);
    do_op("lw102",  0, 2'd2, 0, 32'h102, 32'h0, 32'h0, 1, 0, 4'h0, 32'h0, 1);
    do_op("sz3",    1, 2'd3, 0, 32'h100, 32'h0, 32'h0, 1, 0, 4'h0, 32'h0, 1);
    check("misalign_no_req", req_pulses - base_pulses, 32'd0);

    do_op("sh102",  1, 2'd1, 0, 32'h102, 32'hABCD, 32'h0,        0, 0, 4'b1100, 32'hABCD0000, 7);
    do_op("lw_c",   0, 2'd2, 0, 32'h100, 32'h0,    32'hABCD8765, 0, 0, 4'h0,    32'h0,        7);
    do_op("lh102b", 0, 2'd1, 0, 32'h102, 32'h0,    32'hFFFFABCD, 0, 0, 4'h0,    32'h0,        7);

    // Silent responder: timeout, then a stale pulse must be ignored
    responder_on = 1'b0;
    do_op("tmo", 0, 2'd2, 0, 32'h100, 32'h0, 32'h0, 0, 1, 4'h0, 32'h0, TIMEOUT_CYCLES + 2);
    responder_on = 1'b1;
    base_done = n_done;
    late_pulse = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("late_no_done", n_done - base_done, 32'd0);
    check("late_ready", {31'd0, core_ready}, 32'd1);
    do_op("after_tmo", 0, 2'd2, 0, 32'h100, 32'h0, 32'hABCD8765, 0, 0, 4'h0, 32'h0, 7);

    // Response on the final WAIT cycle beats the timeout
    resp_delay = TIMEOUT_CYCLES;
    do_op("edge_resp", 0, 2'd2, 0, 32'h100, 32'h0, 32'hABCD8765, 0, 0, 4'h0, 32'h0, TIMEOUT_CYCLES + 2);
    resp_delay = 5;

    // Reset during WAIT
    wait_ready();
    q.addr = 32'h100; q.wen = 1'b0; q.mask = 4'h0; q.wdata = 32'h0;
    req_q.push_back(q);
    core_valid = 1'b1; core_wen = 1'b0; core_size = 2'd2; core_unsigned = 1'b0;
    core_addr = 32'h100; core_wdata = 32'h0;
    @(posedge clock); #1;
    core_valid = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_ready",  {31'd0, core_ready},   32'd1);
    check("midrst_done",   {31'd0, core_done},    32'd0);
    check("midrst_reqv",   {31'd0, mem_reqValid}, 32'd0);
    check("midrst_addr",   mem_addr,              32'd0);
    check("midrst_wbmask", {28'd0, mem_wbmask},   32'd0);
    check("midrst_wen",    {31'd0, mem_wen},      32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    do_op("after_rst", 0, 2'd2, 0, 32'h100, 32'h0, 32'hABCD8765, 0, 0, 4'h0, 32'h0, 7);

    // Back-to-back: core_valid held high for three accepted operations
    wait_ready();
    base_pulses = req_pulses;
    base_done   = n_done;
    for (int i = 0; i < 3; i++) begin
      rsp_q.push_back('{rdata: 32'hABCD8765, mis: 1'b0, to: 1'b0});
      req_q.push_back('{addr: 32'h100, wen: 1'b0, mask: 4'h0, wdata: 32'h0});
    end
    core_valid = 1'b1; core_wen = 1'b0; core_size = 2'd2; core_unsigned = 1'b0;
    core_addr = 32'h100;
    acc = 0;
    cyc = 0;
    while (acc < 3 && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (core_ready) acc++;
    end
    @(posedge clock); #1;
    core_valid = 1'b0;
    cyc = 0;
    while (n_done < base_done + 3 && cyc < 200) begin
      @(posedge clock); #1; cyc++;
    end
    repeat (3) @(posedge clock);
    #1;
    check("b2b_dones",      n_done - base_done, 32'd3);
    check("b2b_req_pulses", req_pulses - base_pulses, 32'd3);
    check("ready_exclusive", ready_viol, 32'd0);
    check("rsp_queue_empty", rsp_q.size(), 32'd0);
    check("req_queue_empty", req_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
